// File: rtl/switch_bounce_gen_if.sv
// Bus bundle for switch_bounce_gen.
//   target     requested clean switch level
//   n_bounce   spurious toggle pairs per transition
//   gap_mask   AND-mask limiting each pseudo-random hold length
//   sw         emulated bouncy switch output
//   busy       bounce sequence in progress
//   done_tick  one-cycle pulse once sw has settled
interface switch_bounce_gen_if #(
   parameter int unsigned GAP_W = 16,
   parameter int unsigned NB    = 4
);
   logic             target;
   logic [NB-1:0]    n_bounce;
   logic [GAP_W-1:0] gap_mask;
   logic             sw;
   logic             busy;
   logic             done_tick;

   modport master (
      output target, n_bounce, gap_mask,
      input  sw, busy, done_tick
   );

   modport slave (
      input  target, n_bounce, gap_mask,
      output sw, busy, done_tick
   );
endinterface

// File: rtl/switch_bounce_gen.sv
// Mechanical switch bounce emulator. When target differs from sw, sw toggles
// 2*n_bounce+1 times with pseudo-random hold lengths taken from a 16-bit LFSR,
// ends at the requested level, waits one settle gap, then pulses done_tick.
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    switch_bounce_gen_if slave (target, n_bounce, gap_mask in;
//          sw, busy, done_tick out, all registered)
module switch_bounce_gen #(
   parameter int unsigned GAP_W = 16,
   parameter int unsigned NB    = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input logic               clk,
   input logic               reset,
   switch_bounce_gen_if.slave bus
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam int unsigned TW       = NB + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BOUNCE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [15:0]      lfsr;
   logic [GAP_W-1:0] gap;
   logic [TW-1:0]    tcnt;
   logic             tgt;
   logic             sw_q;
   logic             busy_q;
   logic             done_q;

   logic             lfsr_fb_c;
   logic [GAP_W-1:0] gap_load_c;

   // Taps for x^16+x^14+x^13+x^11+1
   assign lfsr_fb_c  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign gap_load_c = lfsr[GAP_W-1:0] & bus.gap_mask;

   // Free-running LFSR; a nonzero seed keeps it off the all-zero lockup state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= SEED_EFF;
      else       lfsr <= {lfsr[14:0], lfsr_fb_c};
   end

   // Sequencer: outputs registered alongside the state they decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         gap    <= '0;
         tcnt   <= '0;
         tgt    <= 1'b0;
         sw_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (bus.target != sw_q) begin
                  // First toggle lands sw on the new target immediately
                  sw_q   <= ~sw_q;
                  tgt    <= bus.target;
                  tcnt   <= {bus.n_bounce, 1'b0};
                  gap    <= gap_load_c;
                  busy_q <= 1'b1;
                  state  <= S_BOUNCE;
               end
            end
            S_BOUNCE: begin
               if (gap != '0) begin
                  gap <= gap - GAP_W'(1);
               end else if (tcnt != '0) begin
                  sw_q <= ~sw_q;
                  tcnt <= tcnt - TW'(1);
                  gap  <= gap_load_c;
               end else begin
                  // Even toggle count since the first leaves sw == tgt already
                  sw_q   <= tgt;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.sw        = sw_q;
   assign bus.busy      = busy_q;
   assign bus.done_tick = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Self-checking bench for switch_bounce_gen: directed timing scenarios plus a
// randomized run, checked against an event-time reference model.
module tb_switch_bounce_gen;

   localparam int unsigned GAP_W = 8;
   localparam int unsigned NB    = 4;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic clk;
   logic reset;

   switch_bounce_gen_if #(.GAP_W(GAP_W), .NB(NB)) bus ();

   switch_bounce_gen #(.GAP_W(GAP_W), .NB(NB), .SEED(SEED)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Reference model: sequence tracked as absolute edge times of the next event
   logic        m_sw;
   int          m_phase;   // 0 idle, 1 bouncing, 2 done pulse
   int          m_left;
   int          m_next;
   int          m_cyc;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      logic fb;
      fb = ^(x & 16'hB400);
      return {x[14:0], fb};
   endfunction

   function automatic int hold_len(input logic [15:0] l, input logic [GAP_W-1:0] mask);
      logic [GAP_W-1:0] v;
      v = l[GAP_W-1:0] & mask;
      return int'(v) + 1;
   endfunction

   task automatic model_reset();
      m_sw    = 1'b0;
      m_phase = 0;
      m_left  = 0;
      m_next  = 0;
      m_cyc   = 0;
      m_lfsr  = SEED;
   endtask

   // One clock edge: advance the model with the inputs present at the edge
   task automatic step();
      @(posedge clk);
      case (m_phase)
         0: if (bus.target !== m_sw) begin
               m_sw    = bus.target;
               m_left  = 2 * int'(bus.n_bounce);
               m_next  = m_cyc + hold_len(m_lfsr, bus.gap_mask);
               m_phase = 1;
            end
         1: if (m_cyc == m_next) begin
               if (m_left > 0) begin
                  m_sw   = ~m_sw;
                  m_left = m_left - 1;
                  m_next = m_cyc + hold_len(m_lfsr, bus.gap_mask);
               end else begin
                  m_phase = 2;
               end
            end
         default: m_phase = 0;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
      m_cyc  = m_cyc + 1;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Concurrent invariants on every cycle
   task automatic test_invariants();
      logic p_sw, p_busy, p_done;
      p_sw = 1'b0; p_busy = 1'b0; p_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            p_sw = 1'b0; p_busy = 1'b0; p_done = 1'b0;
         end else begin
            total++;
            if (p_done && bus.done_tick) begin
               bad++;
               $display("FAIL inv_done_twice t=%0t done=%b required single-cycle pulse", $time, bus.done_tick);
            end
            total++;
            if (!bus.busy && bus.done_tick) begin
               bad++;
               $display("FAIL inv_busy_done t=%0t busy=%b done=%b required done=0 when busy=0", $time, bus.busy, bus.done_tick);
            end
            total++;
            if (!p_busy && !bus.busy && (bus.sw !== p_sw)) begin
               bad++;
               $display("FAIL inv_idle_sw t=%0t sw=%b required %b", $time, bus.sw, p_sw);
            end
            p_sw = bus.sw; p_busy = bus.busy; p_done = bus.done_tick;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.target = 1'b0; bus.n_bounce = '0; bus.gap_mask = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.sw, bus.busy, bus.done_tick} !== 3'b000) begin
         bad++;
         $display("FAIL reset_outputs sw/busy/done=%b required 000", {bus.sw, bus.busy, bus.done_tick});
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({bus.sw, bus.busy, bus.done_tick} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset cyc=%0d sw/busy/done=%b required 000", i, {bus.sw, bus.busy, bus.done_tick});
         end
      end
   endtask

   // Zero-length gaps, two bounce pairs, rising transition
   task automatic test_fixed_pattern();
      int exp_sw[7]   = '{1, 0, 1, 0, 1, 1, 1};
      int exp_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
      int exp_done[7] = '{0, 0, 0, 0, 0, 1, 0};
      bus.gap_mask = '0;
      bus.n_bounce = NB'(2);
      bus.target   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         total++;
         if (bus.sw !== 1'(exp_sw[i]) || bus.busy !== 1'(exp_busy[i]) || bus.done_tick !== 1'(exp_done[i])) begin
            bad++;
            $display("FAIL fixed_pattern edge=k+%0d sw/busy/done=%b%b%b required %0d%0d%0d",
                     i, bus.sw, bus.busy, bus.done_tick, exp_sw[i], exp_busy[i], exp_done[i]);
         end
      end
   endtask

   // No bounce pairs, falling transition
   task automatic test_single_toggle();
      int exp_busy[3] = '{1, 1, 0};
      int exp_done[3] = '{0, 1, 0};
      bus.gap_mask = '0;
      bus.n_bounce = '0;
      bus.target   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (bus.sw !== 1'b0 || bus.busy !== 1'(exp_busy[i]) || bus.done_tick !== 1'(exp_done[i])) begin
            bad++;
            $display("FAIL single_toggle edge=k+%0d sw/busy/done=%b%b%b required 0%0d%0d",
                     i, bus.sw, bus.busy, bus.done_tick, exp_busy[i], exp_done[i]);
         end
      end
   endtask

   // 31 toggles with holds of 1..4 cycles, repeatable from reset
   task automatic test_long_repeat();
      logic trace[$];
      logic prev;
      int   toggles, last, bad_holds, n, h;
      bus.gap_mask = GAP_W'(3);
      bus.n_bounce = NB'(15);
      bus.target   = 1'b1;
      do_reset();
      prev = 1'b0; toggles = 0; last = 0; bad_holds = 0; n = 0;
      do begin
         step();
         total++;
         if (bus.sw !== m_sw || bus.busy !== (m_phase != 0) || bus.done_tick !== (m_phase == 2)) begin
            bad++;
            $display("FAIL long_model cyc=%0d sw/busy/done=%b%b%b required %b%b%b",
                     n, bus.sw, bus.busy, bus.done_tick, m_sw, m_phase != 0, m_phase == 2);
         end
         trace.push_back(bus.sw);
         if (bus.sw !== prev || bus.done_tick === 1'b1) begin
            if (toggles > 0) begin
               h = n - last;
               if (h < 1 || h > 4) bad_holds++;
            end
            if (bus.sw !== prev) toggles++;
            last = n;
         end
         prev = bus.sw;
         n++;
      end while (m_phase != 0 && n < 400);
      total++;
      if (toggles != 31) begin
         bad++;
         $display("FAIL long_toggles count=%0d required 31", toggles);
      end
      total++;
      if (bad_holds != 0) begin
         bad++;
         $display("FAIL long_holds out_of_range=%0d required 0", bad_holds);
      end
      total++;
      if (bus.sw !== 1'b1 || n >= 400) begin
         bad++;
         $display("FAIL long_final sw=%b cycles=%0d required sw=1 within 400", bus.sw, n);
      end
      do_reset();
      for (int i = 0; i < n; i++) begin
         step();
         total++;
         if (bus.sw !== trace[i]) begin
            bad++;
            $display("FAIL long_repeat cyc=%0d sw=%b required %b", i, bus.sw, trace[i]);
         end
      end
   endtask

   // Target flipped back mid-bounce: finish, one idle edge, then new sequence
   task automatic test_retarget();
      int guard;
      bus.gap_mask = GAP_W'(1);
      bus.n_bounce = NB'(1);
      bus.target   = 1'b0;
      step();
      step();
      bus.target = 1'b1;
      guard = 0;
      while (bus.done_tick !== 1'b1 && guard < 100) begin
         step();
         total++;
         if (bus.sw !== m_sw || bus.busy !== (m_phase != 0)) begin
            bad++;
            $display("FAIL retarget_model sw/busy=%b%b required %b%b", bus.sw, bus.busy, m_sw, m_phase != 0);
         end
         guard++;
      end
      total++;
      if (guard >= 100 || bus.sw !== 1'b0) begin
         bad++;
         $display("FAIL retarget_done guard=%0d sw=%b required done with sw=0", guard, bus.sw);
      end
      step();
      total++;
      if (bus.busy !== 1'b0 || bus.sw !== 1'b0) begin
         bad++;
         $display("FAIL retarget_idle_edge busy/sw=%b%b required 00", bus.busy, bus.sw);
      end
      step();
      total++;
      if (bus.busy !== 1'b1 || bus.sw !== 1'b1) begin
         bad++;
         $display("FAIL retarget_restart busy/sw=%b%b required 11", bus.busy, bus.sw);
      end
      guard = 0;
      while (m_phase != 0 && guard < 100) begin
         step();
         guard++;
      end
   endtask

   // Asynchronous reset in the middle of a bounce sequence
   task automatic test_reset_mid();
      bus.gap_mask = GAP_W'(7);
      bus.n_bounce = NB'(3);
      bus.target   = ~bus.sw;
      repeat (5) step();
      reset = 1'b1;
      model_reset();
      #2;
      total++;
      if ({bus.sw, bus.busy, bus.done_tick} !== 3'b000) begin
         bad++;
         $display("FAIL reset_mid_async sw/busy/done=%b required 000", {bus.sw, bus.busy, bus.done_tick});
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.done_tick !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_no_done done=%b required 0", bus.done_tick);
      end
      bus.target = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         total++;
         if (bus.sw !== m_sw || bus.busy !== (m_phase != 0) || bus.done_tick !== (m_phase == 2)) begin
            bad++;
            $display("FAIL reset_mid_rerun cyc=%0d sw/busy/done=%b%b%b required %b%b%b",
                     i, bus.sw, bus.busy, bus.done_tick, m_sw, m_phase != 0, m_phase == 2);
         end
      end
   endtask

   // Random target, n_bounce and gap_mask activity against the model
   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)  bus.target   = ~bus.target;
         if ($urandom_range(0, 15) == 0) bus.gap_mask = GAP_W'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) bus.n_bounce = NB'($urandom_range(0, 3));
         step();
         total++;
         if (bus.sw !== m_sw || bus.busy !== (m_phase != 0) || bus.done_tick !== (m_phase == 2)) begin
            bad++;
            $display("FAIL random cyc=%0d sw/busy/done=%b%b%b required %b%b%b",
                     i, bus.sw, bus.busy, bus.done_tick, m_sw, m_phase != 0, m_phase == 2);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      fork
         test_invariants();
      join_none
      test_reset();
      test_fixed_pattern();
      test_single_toggle();
      test_long_repeat();
      test_retarget();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
